// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch FIFO.
package if_pkg;

   localparam int INSTR_W        = 32;
   localparam int DEFAULT_ADDR_W = 10;

   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bundles the InstMem read port and the decode-side valid/ready handshake of the fetch unit.
interface inst_fetch_unit_if;
   import if_pkg::*;

   logic [31:0]        mem_address;
   logic               mem_memW;
   logic [31:0]        mem_din;
   logic [INSTR_W-1:0] mem_dout;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [31:0]        out_pc;

   modport master (
      output mem_address, mem_memW, mem_din,
      input  mem_dout,
      output out_valid, out_instr, out_pc,
      input  out_ready
   );

   modport slave (
      input  mem_address, mem_memW, mem_din,
      output mem_dout,
      input  out_valid, out_instr, out_pc,
      output out_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO of fetch entries; flush wins over push, and the head
// output holds its last shown value while the FIFO is empty.
module fetch_fifo
   import if_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output logic         full,
   output logic         empty,
   output logic [CNT_W-1:0] count,
   output fetch_entry_t head
);

   fetch_entry_t            mem_q [DEPTH];
   fetch_entry_t            hold_q;
   logic [PTR_W-1:0]        wr_ptr_q;
   logic [PTR_W-1:0]        rd_ptr_q;
   logic [CNT_W-1:0]        count_q;
   logic                    do_push;
   logic                    do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && !flush && (!full || do_pop);
   assign head    = empty ? hold_q : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (rst_n && do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   // Pointers are PTR_W bits wide, so they wrap modulo DEPTH for free.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hold_q   <= '0;
      end else begin
         hold_q <= head;
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
         end
      end
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: walks the fetch PC through InstMem, queues returned words in a
// prefetch FIFO, and handles redirects with flush and sticky misalignment reporting.
module inst_fetch_unit
   import if_pkg::*;
#(
   parameter int          ADDR_W   = DEFAULT_ADDR_W,
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        align_err,
   inst_fetch_unit_if.master bus
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] fpc_q, fpc_d;
   logic              align_err_q, align_err_d;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count_unused;
   logic              pop;
   logic              fire;
   fetch_entry_t      push_entry;
   fetch_entry_t      head;
   logic              unused_pc_bits;

   assign pop  = !fifo_empty && bus.out_ready;
   // A pop in the same cycle frees a slot, so a full FIFO can still accept the new word.
   assign fire = fetch_en && !redirect_valid && (!fifo_full || pop);

   assign push_entry = '{pc: 32'(fpc_q), instr: bus.mem_dout};

   always_comb begin
      fpc_d       = fpc_q;
      align_err_d = align_err_q;
      if (redirect_valid) begin
         fpc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
         if (redirect_pc[1:0] != 2'b00) align_err_d = 1'b1;
      end else if (fire) begin
         fpc_d = fpc_q + ADDR_W'(4);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fpc_q       <= RESET_PC[ADDR_W-1:0];
         align_err_q <= 1'b0;
      end else begin
         fpc_q       <= fpc_d;
         align_err_q <= align_err_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fire),
      .pop   (pop),
      .flush (redirect_valid),
      .din   (push_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count_unused),
      .head  (head)
   );

   assign bus.mem_address = 32'(fpc_q);
   assign bus.mem_memW    = 1'b0;
   assign bus.mem_din     = 32'h0;
   assign bus.out_valid   = !fifo_empty;
   assign bus.out_pc      = head.pc;
   assign bus.out_instr   = head.instr;
   assign align_err       = align_err_q;

   assign unused_pc_bits = ^redirect_pc[31:ADDR_W];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed cycle table with hand-derived expectations, then
// randomized traffic checked against a queue-based model of the fetch rules.
module tb_inst_fetch_unit;
   import if_pkg::*;

   localparam int DEPTH = 4;

   typedef struct {
      logic        rst_n;
      logic        en;
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        exp_v;
      logic [31:0] exp_pc;
      logic [31:0] exp_ins;
      logic [31:0] exp_addr;
      logic        exp_ae;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        align_err;
   logic [31:0] imem [256];

   int n_vec = 0;
   int n_err = 0;

   vec_t tbl[$];

   fetch_entry_t mq[$];
   logic [31:0]  m_fpc;
   logic         m_ae;
   fetch_entry_t m_last;

   inst_fetch_unit_if bus ();

   inst_fetch_unit #(.ADDR_W(10), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .align_err      (align_err),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   assign bus.mem_dout = imem[bus.mem_address[9:2]];

   function automatic logic [31:0] wordat(input logic [31:0] a);
      logic [7:0] b;
      b = a[7:0];
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic e, input logic rv, input logic [31:0] rpc,
                      input logic rdy, input logic ev, input logic [31:0] epc,
                      input logic [31:0] eins, input logic [31:0] eaddr, input logic eae);
      vec_t v;
      v = '{r, e, rv, rpc, rdy, ev, epc, eins, eaddr, eae};
      tbl.push_back(v);
   endtask

   task automatic drive(input logic r, input logic e, input logic rv, input logic [31:0] rpc, input logic rdy);
      rst_n          = r;
      fetch_en       = e;
      redirect_valid = rv;
      redirect_pc    = rpc;
      bus.out_ready  = rdy;
   endtask

   task automatic model_reset();
      mq.delete();
      m_fpc  = 32'h0;
      m_ae   = 1'b0;
      m_last = '0;
   endtask

   // Apply one clock edge to the reference model, given the inputs held this cycle.
   task automatic model_edge();
      fetch_entry_t shown;
      fetch_entry_t e;
      logic popv, firev;
      if (!rst_n) begin
         model_reset();
         return;
      end
      shown  = (mq.size() > 0) ? mq[0] : m_last;
      popv   = (mq.size() > 0) && bus.out_ready;
      firev  = fetch_en && !redirect_valid && ((mq.size() < DEPTH) || popv);
      m_last = shown;
      if (redirect_valid) begin
         mq.delete();
         m_fpc = redirect_pc & 32'h0000_03FC;
         if (redirect_pc[1:0] != 2'b00) m_ae = 1'b1;
      end else begin
         if (popv) void'(mq.pop_front());
         if (firev) begin
            e.pc    = m_fpc;
            e.instr = wordat(m_fpc);
            mq.push_back(e);
            m_fpc = (m_fpc + 32'd4) % 32'd1024;
         end
      end
   endtask

   task automatic model_check(input int idx);
      fetch_entry_t shown;
      shown = (mq.size() > 0) ? mq[0] : m_last;
      chk("rnd_valid", idx, 32'(bus.out_valid), 32'(mq.size() > 0));
      chk("rnd_pc",    idx, bus.out_pc,         shown.pc);
      chk("rnd_instr", idx, bus.out_instr,      shown.instr);
      chk("rnd_addr",  idx, bus.mem_address,    m_fpc);
      chk("rnd_align", idx, 32'(align_err),     32'(m_ae));
      chk("rnd_memW",  idx, 32'(bus.mem_memW),  32'h0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) imem[i] = wordat(32'(i * 4));

      // Streaming from reset
      add(1,1,0,0,1, 0,32'h000,32'h00000000,32'h000,0);
      add(1,1,0,0,1, 1,32'h000,32'h03020100,32'h004,0);
      add(1,1,0,0,1, 1,32'h004,32'h07060504,32'h008,0);
      add(1,1,0,0,1, 1,32'h008,32'h0B0A0908,32'h00C,0);
      add(0,1,0,0,1, 1,32'h00C,32'h0F0E0D0C,32'h010,0);
      // Backpressure for 10 cycles, then release
      add(1,1,0,0,0, 0,32'h000,32'h00000000,32'h000,0);
      add(1,1,0,0,0, 1,32'h000,32'h03020100,32'h004,0);
      add(1,1,0,0,0, 1,32'h000,32'h03020100,32'h008,0);
      add(1,1,0,0,0, 1,32'h000,32'h03020100,32'h00C,0);
      for (int i = 0; i < 6; i++) add(1,1,0,0,0, 1,32'h000,32'h03020100,32'h010,0);
      add(1,1,0,0,1, 1,32'h000,32'h03020100,32'h010,0);
      add(1,1,0,0,1, 1,32'h004,32'h07060504,32'h014,0);
      add(1,1,0,0,1, 1,32'h008,32'h0B0A0908,32'h018,0);
      add(1,1,0,0,1, 1,32'h00C,32'h0F0E0D0C,32'h01C,0);
      add(1,1,0,0,1, 1,32'h010,32'h13121110,32'h020,0);
      // Redirect to 0x40 while full
      add(1,1,0,0,0,          1,32'h014,32'h17161514,32'h024,0);
      add(1,1,1,32'h40,0,     1,32'h014,32'h17161514,32'h024,0);
      add(1,1,0,0,1,          0,32'h014,32'h17161514,32'h040,0);
      add(1,1,0,0,1,          1,32'h040,32'h43424140,32'h044,0);
      // Redirect to 0x3F8 and wrap
      add(1,1,1,32'h3F8,1,    1,32'h044,32'h47464544,32'h048,0);
      add(1,1,0,0,1,          0,32'h044,32'h47464544,32'h3F8,0);
      add(1,1,0,0,1,          1,32'h3F8,32'hFBFAF9F8,32'h3FC,0);
      add(1,1,0,0,1,          1,32'h3FC,32'hFFFEFDFC,32'h000,0);
      add(1,1,0,0,1,          1,32'h000,32'h03020100,32'h004,0);
      // Misaligned redirect to 0x21
      add(1,1,1,32'h21,1,     1,32'h004,32'h07060504,32'h008,0);
      add(1,1,0,0,1,          0,32'h004,32'h07060504,32'h020,1);
      add(1,1,0,0,1,          1,32'h020,32'h23222120,32'h024,1);
      // Queue three entries, then a one-cycle reset
      add(1,1,0,0,0,          1,32'h024,32'h27262524,32'h028,1);
      add(1,1,0,0,0,          1,32'h024,32'h27262524,32'h02C,1);
      add(0,1,0,0,0,          1,32'h024,32'h27262524,32'h030,1);
      add(1,1,0,0,1,          0,32'h000,32'h00000000,32'h000,0);
      add(1,1,0,0,1,          1,32'h000,32'h03020100,32'h004,0);
      // fetch_en low: drain only
      add(1,0,0,0,0,          1,32'h004,32'h07060504,32'h008,0);
      add(1,0,0,0,1,          1,32'h004,32'h07060504,32'h008,0);
      add(1,0,0,0,1,          0,32'h004,32'h07060504,32'h008,0);
      add(1,1,0,0,1,          0,32'h004,32'h07060504,32'h008,0);
      add(1,1,0,0,1,          1,32'h008,32'h0B0A0908,32'h00C,0);

      drive(0, 0, 0, 32'h0, 0);
      repeat (2) @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         drive(tbl[i].rst_n, tbl[i].en, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
         @(negedge clk);
         $display("vec %0d: valid=%0b pc=%h instr=%h addr=%h align=%0b", i,
                  bus.out_valid, bus.out_pc, bus.out_instr, bus.mem_address, align_err);
         chk("valid", i, 32'(bus.out_valid), 32'(tbl[i].exp_v));
         chk("pc",    i, bus.out_pc,         tbl[i].exp_pc);
         chk("instr", i, bus.out_instr,      tbl[i].exp_ins);
         chk("addr",  i, bus.mem_address,    tbl[i].exp_addr);
         chk("align", i, 32'(align_err),     32'(tbl[i].exp_ae));
         chk("memW",  i, 32'(bus.mem_memW),  32'h0);
         chk("din",   i, bus.mem_din,        32'h0);
         @(posedge clk);
         #1;
      end

      // Randomized traffic against the model, starting from a fresh reset
      drive(0, 0, 0, 32'h0, 0);
      @(negedge clk);
      model_edge();
      @(posedge clk);
      #1;
      for (int c = 0; c < 3000; c++) begin
         logic [31:0] rpc;
         rpc = $urandom;
         if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
         drive(($urandom_range(0, 199) != 0),
               ($urandom_range(0, 9) < 8),
               ($urandom_range(0, 19) == 0),
               rpc,
               ($urandom_range(0, 9) < 6));
         @(negedge clk);
         model_check(c);
         model_edge();
         @(posedge clk);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
